// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads, optional write-to-read
// bypass, highest-port-wins write priority and a self-clearing sequencer.
module regfile_mp #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 6,
   parameter int                DEPTH     = 64,
   parameter int                NUM_RD    = 2,
   parameter int                NUM_WR    = 2,
   parameter int                BYPASS    = 1,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     clear_req,
   output logic                     busy,
   output logic                     wr_conflict,
   input  logic                     VDD,
   input  logic                     VSS
);

   typedef enum logic {CLEAR, READY} state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   clr_cnt_reg;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic [ADDR_W-1:0]   wa [NUM_WR];
   logic [DATA_W-1:0]   wd [NUM_WR];
   logic [NUM_WR-1:0]   wr_ok;
   logic [ADDR_W-1:0]   ra [NUM_RD];
   logic [DATA_W-1:0]   rd_next [NUM_RD];
   logic                conflict_next;
   logic                accept;

   // Supply pins only pass through the netlist for the APR flow.
   logic unused_supply;
   assign unused_supply = VDD ^ VSS;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < (ADDR_W+1)'(DEPTH);
   endfunction

   // A clear request on a READY edge takes priority over any write on that edge.
   assign accept = (state_reg == READY) && !clear_req;
   assign busy   = (state_reg == CLEAR);

   generate
      for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
         assign wa[gi]    = wr_addr[gi*ADDR_W +: ADDR_W];
         assign wd[gi]    = wr_data[gi*DATA_W +: DATA_W];
         assign wr_ok[gi] = accept && wr_en[gi] && in_range(wa[gi]);
      end
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         assign ra[gi] = rd_addr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   always_comb begin
      conflict_next = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (wr_ok[i] && wr_ok[j] && (wa[i] == wa[j])) conflict_next = 1'b1;
         end
      end
   end

   // Ascending port scan lets the highest-index matching writer win the forward.
   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         rd_next[r] = '0;
         if (in_range(ra[r])) begin
            rd_next[r] = mem[ra[r]];
            if (BYPASS != 0) begin
               for (int w = 0; w < NUM_WR; w++) begin
                  if (wr_ok[w] && (wa[w] == ra[r])) rd_next[r] = wd[w];
               end
            end
         end
      end
   end

   // Array has no reset so it can map onto RAM-style storage; rst freezes it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_reg == CLEAR) begin
            mem[clr_cnt_reg] <= CLEAR_VAL;
         end else begin
            for (int w = 0; w < NUM_WR; w++) begin
               if (wr_ok[w]) mem[wa[w]] <= wd[w];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= CLEAR;
         clr_cnt_reg <= '0;
         rd_data     <= '0;
         wr_conflict <= 1'b0;
      end else begin
         case (state_reg)
            CLEAR: begin
               rd_data     <= '0;
               wr_conflict <= 1'b0;
               if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                  state_reg <= READY;
               end else begin
                  clr_cnt_reg <= clr_cnt_reg + 1'b1;
               end
            end
            default: begin
               if (clear_req) begin
                  state_reg   <= CLEAR;
                  clr_cnt_reg <= '0;
               end
               wr_conflict <= conflict_next;
               for (int r = 0; r < NUM_RD; r++) begin
                  rd_data[r*DATA_W +: DATA_W] <= rd_next[r];
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Random and directed bench for regfile_mp: two instances (full depth with bypass,
// short depth without bypass) run against a behavioural array model.
module tb_regfile_mp;

   localparam int          DEPTH_C [2] = '{64, 40};
   localparam bit          BYP_C   [2] = '{1'b1, 1'b0};
   localparam logic [15:0] CV_C    [2] = '{16'h0000, 16'h5A5A};

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wr_en;
   logic [11:0] wr_addr;
   logic [31:0] wr_data;
   logic [11:0] rd_addr;
   logic        clear_req;
   logic        vdd = 1'b1;
   logic        vss = 1'b0;
   logic [31:0] rd_d0, rd_d1;
   logic        busy0, busy1, conf0, conf1;

   int checks   = 0;
   int failures = 0;

   logic [15:0] mm  [2][64];
   logic [15:0] erd [2][2];
   bit          econf [2];
   int          clear_left [2];

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .NUM_RD(2), .NUM_WR(2),
                .BYPASS(1), .CLEAR_VAL(16'h0000)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_d0), .clear_req(clear_req), .busy(busy0),
      .wr_conflict(conf0), .VDD(vdd), .VSS(vss));

   regfile_mp #(.DATA_W(16), .ADDR_W(6), .DEPTH(40), .NUM_RD(2), .NUM_WR(2),
                .BYPASS(0), .CLEAR_VAL(16'h5A5A)) dut_nb (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_d1), .clear_req(clear_req), .busy(busy1),
      .wr_conflict(conf1), .VDD(vdd), .VSS(vss));

   task automatic chk(input string tag, input int k, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s inst%0d got=%h exp=%h", tag, k, got, exp);
      end
   endtask

   // Model: reads on an edge see the array after that edge's writes when bypassing,
   // before them otherwise; clearing simply walks the array low to high.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         logic [15:0] old_m [64];
         int          hits [64];
         int          a;
         old_m = mm[k];
         foreach (hits[i]) hits[i] = 0;
         if (rst) begin
            clear_left[k] = DEPTH_C[k];
            erd[k][0] = 16'h0; erd[k][1] = 16'h0; econf[k] = 1'b0;
         end else if (clear_left[k] > 0) begin
            mm[k][DEPTH_C[k] - clear_left[k]] = CV_C[k];
            clear_left[k]--;
            erd[k][0] = 16'h0; erd[k][1] = 16'h0; econf[k] = 1'b0;
         end else begin
            econf[k] = 1'b0;
            if (clear_req) begin
               clear_left[k] = DEPTH_C[k];
            end else begin
               for (int w = 0; w < 2; w++) begin
                  a = int'(wr_addr[w*6 +: 6]);
                  if (wr_en[w] && a < DEPTH_C[k]) begin
                     mm[k][a] = wr_data[w*16 +: 16];
                     hits[a]++;
                     if (hits[a] > 1) econf[k] = 1'b1;
                  end
               end
            end
            for (int r = 0; r < 2; r++) begin
               a = int'(rd_addr[r*6 +: 6]);
               if (a >= DEPTH_C[k])  erd[k][r] = 16'h0;
               else if (BYP_C[k])    erd[k][r] = mm[k][a];
               else                  erd[k][r] = old_m[a];
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      model_edge();
      $display("t=%0t rst=%0b clr=%0b we=%b wa=%h wd=%h ra=%h | rd0=%h rd1=%h busy=%b%b conf=%b%b",
               $time, rst, clear_req, wr_en, wr_addr, wr_data, rd_addr, rd_d0, rd_d1,
               busy0, busy1, conf0, conf1);
      chk("busy",     0, 32'(busy0), 32'(clear_left[0] > 0));
      chk("busy",     1, 32'(busy1), 32'(clear_left[1] > 0));
      chk("conflict", 0, 32'(conf0), 32'(econf[0]));
      chk("conflict", 1, 32'(conf1), 32'(econf[1]));
      chk("rd_data",  0, rd_d0, {erd[0][1], erd[0][0]});
      chk("rd_data",  1, rd_d1, {erd[1][1], erd[1][0]});
   endtask

   task automatic rand_traffic(input int clr_odds);
      wr_en     = 2'($urandom);
      wr_addr   = 12'($urandom);
      wr_data   = $urandom;
      rd_addr   = 12'($urandom);
      if ($urandom_range(0, 3) == 0) wr_addr[11:6] = wr_addr[5:0];
      clear_req = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
   endtask

   // Counts edges until each instance drops busy; bounded so a stuck sequencer fails.
   task automatic count_busy(input string tag);
      int n [2];
      n = '{0, 0};
      for (int c = 1; c <= 150 && (n[0] == 0 || n[1] == 0); c++) begin
         rand_traffic(0);
         cycle();
         if (n[0] == 0 && busy0 === 1'b0) n[0] = c;
         if (n[1] == 0 && busy1 === 1'b0) n[1] = c;
      end
      chk({tag, "_busy_len"}, 0, 32'(n[0]), 32'(DEPTH_C[0]));
      chk({tag, "_busy_len"}, 1, 32'(n[1]), 32'(DEPTH_C[1]));
   endtask

   task automatic read_pass();
      for (int i = 0; i < 64; i++) begin
         wr_en   = 2'b00;
         rd_addr = {6'(63 - i), 6'(i)};
         cycle();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      foreach (mm[k, i]) mm[k][i] = 16'h0;
      clear_left = '{0, 0};
      rst = 1'b1; clear_req = 1'b0; wr_en = 2'b00;
      wr_addr = '0; wr_data = '0; rd_addr = '0;

      cycle();
      cycle();
      rst = 1'b0;
      count_busy("reset");
      read_pass();

      for (int i = 0; i < 64; i++) begin
         wr_en   = 2'b01;
         wr_addr = {6'd0, 6'(i)};
         wr_data = {16'h0, 16'(i * 16'h2408)};
         rd_addr = {6'(i), 6'(i - 1)};
         cycle();
      end
      read_pass();

      wr_en = 2'b11; wr_addr = {6'd5, 6'd5}; wr_data = {16'h5555, 16'hAAAA};
      rd_addr = {6'd0, 6'd1};
      cycle();
      chk("conflict_set", 0, 32'(conf0), 32'd1);
      chk("conflict_set", 1, 32'(conf1), 32'd1);
      wr_en = 2'b00; rd_addr = {6'd5, 6'd5};
      cycle();
      chk("conflict_clr", 0, 32'(conf0), 32'd0);
      chk("conflict_win", 0, rd_d0, 32'h5555_5555);
      chk("conflict_win", 1, rd_d1, 32'h5555_5555);

      clear_req = 1'b1; wr_en = 2'b01; wr_addr = {6'd0, 6'd3}; wr_data = {16'h0, 16'hBEEF};
      rd_addr = {6'd3, 6'd3};
      cycle();
      clear_req = 1'b0;
      count_busy("clear");
      wr_en = 2'b00; rd_addr = {6'd3, 6'd3};
      cycle();
      chk("clear_drop", 0, rd_d0, {2{CV_C[0]}});
      chk("clear_drop", 1, rd_d1, {2{CV_C[1]}});
      read_pass();

      wr_en = 2'b01; wr_addr = {6'd0, 6'd9}; wr_data = {16'h0, 16'h1234};
      rd_addr = {6'd0, 6'd9};
      cycle();
      chk("bypass_same", 0, {16'h0, rd_d0[15:0]}, 32'h1234);
      chk("bypass_same", 1, {16'h0, rd_d1[15:0]}, {16'h0, CV_C[1]});
      wr_en = 2'b00;
      cycle();
      chk("bypass_next", 0, {16'h0, rd_d0[15:0]}, 32'h1234);
      chk("bypass_next", 1, {16'h0, rd_d1[15:0]}, 32'h1234);

      clear_req = 1'b1; wr_en = 2'b00;
      cycle();
      clear_req = 1'b0;
      for (int i = 0; i < 30; i++) begin
         rand_traffic(0);
         cycle();
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      count_busy("midclear");
      read_pass();

      for (int i = 0; i < 400; i++) begin
         rand_traffic(64);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the 2R/1W, 16-bit, 64-entry regfile.
- Generalised in data width, depth, read-port count and write-port count.
- Adds registered reads with optional write-to-read bypass, defined write-port conflict priority, and a self-clearing sequencer run after reset or on request.
- Sits in the same APR flow as the existing regfile; supply pins are carried through unchanged.

Parameters:
- DATA_W, 16, data width in bits
- ADDR_W, 6, address width in bits
- DEPTH, 64, number of entries; must be <= 2**ADDR_W
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- BYPASS, 1, 1 = same-edge write data forwarded to reads; 0 = reads return pre-write contents
- CLEAR_VAL, 0, value written to every entry by the clear sequence (DATA_W bits)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses; port w occupies bits [w*ADDR_W +: ADDR_W]
- wr_data  in  NUM_WR*DATA_W  packed write data
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- clear_req  in  1  one-cycle request to rerun the clear sequence
- busy  out  1  high while the clear sequence runs
- wr_conflict  out  1  registered flag: two or more enabled write ports targeted the same address
- VDD  in  1  supply; no logic function
- VSS  in  1  supply; no logic function

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (posedge with rst=1):
  - state <= CLEAR, clr_cnt <= 0.
  - rd_data <= 0, wr_conflict <= 0.
  - Array contents are not touched while rst is held.
- States: CLEAR, READY. busy = (state == CLEAR), decoded directly from the state register.
- CLEAR state (rst=0):
  - Each edge writes mem[clr_cnt] <= CLEAR_VAL.
  - If clr_cnt == DEPTH-1, go to READY; else clr_cnt++.
  - busy is therefore high for exactly DEPTH edges after reset release.
  - User writes are ignored; rd_data <= 0; wr_conflict <= 0.
- READY → CLEAR: on an edge with clear_req=1, clr_cnt <= 0. Writes presented on that edge are dropped (clear_req has priority). clear_req while already in CLEAR is ignored.
- rst asserted mid-CLEAR restarts the sequence at clr_cnt=0.
- Writes (READY only):
  - For each w with wr_en[w]=1 and wr_addr[w] < DEPTH: mem[wr_addr[w]] <= wr_data[w].
  - Same address on several enabled ports: the highest-index port wins, and wr_conflict <= 1 on that edge; otherwise wr_conflict <= 0.
  - Out-of-range addresses (>= DEPTH) are dropped and do not count toward conflicts.
- Reads (READY only):
  - 1-cycle latency: rd_data[r] <= mem[rd_addr[r]] at posedge.
  - Out-of-range rd_addr returns 0.
  - Any number of read ports may read the same address.
- Bypass:
  - BYPASS=1: if a same-edge accepted write targets rd_addr[r], rd_data[r] <= that write's data, using the winning (highest-index) port.
  - BYPASS=0: rd_data[r] <= the old contents.
- No combinational path from any input to rd_data, busy or wr_conflict.

Test Plan:
- Reset release: rst=1 for 2 edges then 0 → busy high for exactly 64 edges, then 0; reading addresses 0..63 returns 16'h0000.
- Pattern fill: write i*16'h2408 to entry i on port 0 (i = 0..63), then read entry i-1 on rd port 0 and entry i on rd port 1 → each returns i*16'h2408 truncated to 16 bits, one cycle after the address is applied.
- Conflict: wr_en=2'b11, both ports address 6'd5, data 16'hAAAA on port 0 and 16'h5555 on port 1 → entry 5 reads 16'h5555; wr_conflict=1 for exactly one cycle.
- Bypass: BYPASS=1, write 16'h1234 to address 9 while rd_addr_0=9 on the same edge → rd_data_0=16'h1234 next cycle. With BYPASS=0 → old value 16'h0000 next cycle, then 16'h1234 the cycle after.
- Clear request: fill all entries, pulse clear_req together with a write of 16'hBEEF to address 3 → write dropped; busy high for 64 cycles; afterwards all entries read CLEAR_VAL.
- Reset mid-clear: assert rst at clr_cnt=30 → sequence restarts at 0; busy stays high for a full 64 edges after release.
